// File: rtl/memwb_stage_if.sv
// Accelerator bus port between the memory/writeback stage (master) and
// the accelerator (slave). req is held until a single-cycle ack; rdata is
// valid alongside ack. err is a one-cycle timeout indication.
interface memwb_stage_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, err,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, err,
        output ack, rdata
    );
endinterface

// File: rtl/memwb_stage.sv
// Combined memory/writeback stage sitting right after execute.
// - BRAM port is driven combinationally from execute's registered outputs;
//   BRAM ops never stall.
// - Bus ops (bus read or bus write) run through an IDLE -> REQ -> DONE FSM
//   and hold the upstream pipeline with stall until the DONE cycle, where the
//   held instruction retires.
// - Writeback enable/address/ALU result/source select are registered; the
//   writeback data is a mux on the registered select.
// Optional feature: define BUS_TIMEOUT_EN to abort a bus request after
// BUS_TIMEOUT cycles without ack (rdata forced to all ones, bus_err pulse).
module memwb_stage #(
    parameter int DATA_W      = 16,
    parameter int DMEM_AW     = 10,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    // execute stage outputs
    input  logic               ex_regwrite,
    input  logic               ex_memtoreg,
    input  logic               ex_bustoreg,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic               ex_buswrite,
    input  logic [DATA_W-1:0]  ex_alu_out,
    input  logic [DATA_W-1:0]  ex_alu_src2,
    input  logic [3:0]         ex_regwraddr,
    // data BRAM port
    output logic               dmem_en,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    // accelerator bus
    memwb_stage_if.master      bus,
    // pipeline control and writeback
    output logic               stall,
    output logic               wb_regwrite,
    output logic [3:0]         wb_regwraddr,
    output logic [DATA_W-1:0]  wb_regwrdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [DATA_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_bus_rdata;

    logic                r_wb_regwrite;
    logic [3:0]          r_wb_regwraddr;
    logic [DATA_W-1:0]   r_wb_alu;
    logic                r_wb_memtoreg;
    logic                r_wb_bustoreg;

    logic                w_bus_op;
    logic                w_stall;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_bus_err;
`endif

    // BRAM port, bus-op decode and stall: pure functions of execute's outputs
    always_comb begin
        dmem_en    = ex_memread | ex_memwrite;
        dmem_we    = ex_memwrite;
        dmem_addr  = ex_alu_out[DMEM_AW-1:0];
        dmem_wdata = ex_alu_src2;
        w_bus_op   = ex_bustoreg | ex_buswrite;
        // the DONE cycle is the retire cycle of the held bus instruction;
        // reset forces stall low so upstream is released immediately
        w_stall    = rst_n & w_bus_op & (r_state != ST_DONE);
    end

    // Bus transaction FSM: latches the request, waits for ack, captures rdata
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_bus_op) begin
                        r_state     <= ST_REQ;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= ex_buswrite;
                        r_bus_addr  <= ex_alu_out;
                        r_bus_wdata <= ex_alu_src2;
`ifdef BUS_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end else begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus.ack) begin
                        // an ack on the timeout cycle still wins
                        r_state     <= ST_DONE;
                        r_bus_req   <= 1'b0;
                        r_bus_rdata <= bus.rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_state     <= ST_DONE;
                        r_bus_req   <= 1'b0;
                        r_bus_rdata <= {DATA_W{1'b1}};
                        r_bus_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`else
                    else begin
                        r_state <= ST_REQ;
                    end
`endif
                end
                ST_DONE: begin
                    // held instruction retires now; it is not re-issued
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Writeback register: loads the accepted instruction, or a bubble on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_regwrite  <= 1'b0;
            r_wb_regwraddr <= 4'd0;
            r_wb_alu       <= '0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_bustoreg  <= 1'b0;
        end else if (!w_stall) begin
            r_wb_regwrite  <= ex_regwrite;
            r_wb_regwraddr <= ex_regwraddr;
            r_wb_alu       <= ex_alu_out;
            r_wb_memtoreg  <= ex_memtoreg;
            r_wb_bustoreg  <= ex_bustoreg;
        end else begin
            r_wb_regwrite  <= 1'b0;
        end
    end

    // Writeback data source select; BRAM read data has priority over bus data
    always_comb begin
        wb_regwrdata = r_wb_alu;
        if (r_wb_memtoreg) begin
            wb_regwrdata = dmem_rdata;
        end else if (r_wb_bustoreg) begin
            wb_regwrdata = r_bus_rdata;
        end else begin
            wb_regwrdata = r_wb_alu;
        end
    end

    assign stall        = w_stall;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_regwraddr = r_wb_regwraddr;
    assign bus.req      = r_bus_req;
    assign bus.we       = r_bus_we;
    assign bus.addr     = r_bus_addr;
    assign bus.wdata    = r_bus_wdata;
`ifdef BUS_TIMEOUT_EN
    assign bus.err      = r_bus_err;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: ALU writeback, BRAM store/load, bus read
// and write handshakes, reset in the middle of a bus request, source-select
// priority and the (optionally enabled) bus timeout.
module tb_memwb_stage;

    localparam int DATA_W  = 16;
    localparam int DMEM_AW = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ex_regwrite, ex_memtoreg, ex_bustoreg;
    logic               ex_memread, ex_memwrite, ex_buswrite;
    logic [DATA_W-1:0]  ex_alu_out, ex_alu_src2;
    logic [3:0]         ex_regwraddr;
    logic               dmem_en, dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata = '0;
    logic               stall, wb_regwrite;
    logic [3:0]         wb_regwraddr;
    logic [DATA_W-1:0]  wb_regwrdata;

    int check_count = 0;
    int error_count = 0;
    int we_pulses   = 0;

    memwb_stage_if #(.DATA_W(DATA_W)) bus_if ();

    memwb_stage #(
        .DATA_W(DATA_W), .DMEM_AW(DMEM_AW), .BUS_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_bustoreg(ex_bustoreg), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_buswrite(ex_buswrite),
        .ex_alu_out(ex_alu_out), .ex_alu_src2(ex_alu_src2),
        .ex_regwraddr(ex_regwraddr),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .bus(bus_if),
        .stall(stall), .wb_regwrite(wb_regwrite),
        .wb_regwraddr(wb_regwraddr), .wb_regwrdata(wb_regwrdata)
    );

    always #5 clk = ~clk;

    // BRAM model: synchronous read-first memory
    logic [DATA_W-1:0] mem [0:(1<<DMEM_AW)-1];
    always @(posedge clk) begin
        if (dmem_en) begin
            if (dmem_we) mem[dmem_addr] <= dmem_wdata;
            dmem_rdata <= mem[dmem_addr];
        end
    end

    // count BRAM write strobes seen at clock edges
    always @(posedge clk) begin
        if (dmem_we) we_pulses <= we_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop;
        ex_regwrite  = 1'b0; ex_memtoreg = 1'b0; ex_bustoreg = 1'b0;
        ex_memread   = 1'b0; ex_memwrite = 1'b0; ex_buswrite = 1'b0;
        ex_alu_out   = 16'h0000; ex_alu_src2 = 16'h0000; ex_regwraddr = 4'd0;
    endtask

    // Presents one bus instruction, plays the accelerator (ack after ack_at
    // REQ cycles, 0 = never), and tallies req/stall/err/writeback cycles.
    task automatic bus_op(input string tag, input logic bw, input logic mtr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic rw, input logic [3:0] dest,
                          input int ack_at, input logic [15:0] rdat, input int iters,
                          input int exp_req, input int exp_stall, input int exp_wb,
                          input logic [15:0] exp_data, input int exp_err);
        int req_n = 0, stall_n = 0, wb_n = 0, err_n = 0;
        logic done = 1'b0, cleared = 1'b0;
        logic cap_we = 1'b0;
        logic [15:0] cap_addr = 16'h0000, cap_wdata = 16'h0000;
        set_nop();
        ex_buswrite = bw; ex_bustoreg = ~bw; ex_regwrite = rw; ex_regwraddr = dest;
        ex_memtoreg = mtr; ex_memread = mtr;
        ex_alu_out  = addr; ex_alu_src2 = wdata;
        for (int c = 0; c < iters; c++) begin
            #1;
            if (bus_if.req) begin
                req_n++;
                if (req_n == 1) begin
                    cap_we = bus_if.we; cap_addr = bus_if.addr; cap_wdata = bus_if.wdata;
                end
                if (req_n == ack_at) begin
                    bus_if.ack = 1'b1; bus_if.rdata = rdat;
                end
            end
            if (stall) stall_n++;
            if (bus_if.err) err_n++;
            if (wb_regwrite) begin
                wb_n++;
                check_eq({tag, "_wb_addr"}, 32'(wb_regwraddr), 32'(dest));
                check_eq({tag, "_wb_data"}, 32'(wb_regwrdata), 32'(exp_data));
            end
            if (!cleared && !stall) done = 1'b1;
            tick();
            bus_if.ack = 1'b0; bus_if.rdata = 16'h0000;
            if (done && !cleared) begin
                set_nop();
                cleared = 1'b1;
            end
        end
        check_eq({tag, "_req_cycles"},   32'(req_n),   32'(exp_req));
        check_eq({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        check_eq({tag, "_wb_count"},     32'(wb_n),    32'(exp_wb));
        check_eq({tag, "_err_pulses"},   32'(err_n),   32'(exp_err));
        if (exp_req > 0) begin
            check_eq({tag, "_bus_we"},    32'(cap_we),    32'(bw));
            check_eq({tag, "_bus_addr"},  32'(cap_addr),  32'(addr));
            if (bw) check_eq({tag, "_bus_wdata"}, 32'(cap_wdata), 32'(wdata));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.ack = 1'b0; bus_if.rdata = 16'h0000;
        set_nop();

        // reset state
        tick(); tick();
        check_eq("rst_wb_regwrite",  32'(wb_regwrite),  32'd0);
        check_eq("rst_wb_regwraddr", 32'(wb_regwraddr), 32'd0);
        check_eq("rst_wb_regwrdata", 32'(wb_regwrdata), 32'd0);
        check_eq("rst_stall",        32'(stall),        32'd0);
        check_eq("rst_bus_req",      32'(bus_if.req),   32'd0);
        check_eq("rst_bus_err",      32'(bus_if.err),   32'd0);
        rst_n = 1'b1;

        // ALU op
        ex_regwrite = 1'b1; ex_regwraddr = 4'd5; ex_alu_out = 16'h1234;
        #1 check_eq("alu_stall", 32'(stall), 32'd0);
        tick();
        set_nop();
        check_eq("alu_wb_regwrite", 32'(wb_regwrite),  32'd1);
        check_eq("alu_wb_addr",     32'(wb_regwraddr), 32'd5);
        check_eq("alu_wb_data",     32'(wb_regwrdata), 32'h1234);
        check_eq("alu_stall_after", 32'(stall),        32'd0);
        tick();
        check_eq("nop_wb_regwrite", 32'(wb_regwrite),  32'd0);

        // store 0xBEEF to 0x0010, then load it to r3
        ex_memwrite = 1'b1; ex_alu_out = 16'h0010; ex_alu_src2 = 16'hBEEF;
        #1;
        check_eq("st_dmem_en",    32'(dmem_en),    32'd1);
        check_eq("st_dmem_we",    32'(dmem_we),    32'd1);
        check_eq("st_dmem_addr",  32'(dmem_addr),  32'h010);
        check_eq("st_dmem_wdata", 32'(dmem_wdata), 32'hBEEF);
        check_eq("st_stall",      32'(stall),      32'd0);
        tick();
        set_nop();
        ex_memread = 1'b1; ex_memtoreg = 1'b1; ex_regwrite = 1'b1;
        ex_regwraddr = 4'd3; ex_alu_out = 16'h0010;
        #1;
        check_eq("ld_dmem_we",     32'(dmem_we),     32'd0);
        check_eq("ld_dmem_en",     32'(dmem_en),     32'd1);
        check_eq("st_no_wb",       32'(wb_regwrite), 32'd0);
        tick();
        set_nop();
        check_eq("ld_wb_regwrite", 32'(wb_regwrite),  32'd1);
        check_eq("ld_wb_addr",     32'(wb_regwraddr), 32'd3);
        check_eq("ld_wb_data",     32'(wb_regwrdata), 32'hBEEF);
        check_eq("st_we_pulses",   32'(we_pulses),    32'd1);
        tick();

        // bus read, ack on 3rd REQ cycle
        bus_op("busrd", 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1, 4'd7,
               3, 16'h00A5, 8, 3, 4, 1, 16'h00A5, 0);
        // bus write, ack on 1st REQ cycle, no writeback
        bus_op("buswr", 1'b1, 1'b0, 16'h8002, 16'h5555, 1'b0, 4'd0,
               1, 16'h0000, 6, 1, 2, 0, 16'h0000, 0);
        // bus read with memtoreg also set: BRAM read data takes priority
        bus_op("prio", 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 4'd4,
               1, 16'h1111, 6, 1, 2, 1, 16'hBEEF, 0);

        // reset asserted while the request is outstanding
        ex_bustoreg = 1'b1; ex_regwrite = 1'b1; ex_regwraddr = 4'd6; ex_alu_out = 16'h9000;
        tick(); tick();
        check_eq("rstreq_req_before", 32'(bus_if.req), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("rstreq_req_after",   32'(bus_if.req),  32'd0);
        check_eq("rstreq_stall_after", 32'(stall),       32'd0);
        check_eq("rstreq_wb",          32'(wb_regwrite), 32'd0);
        rst_n = 1'b1;
        set_nop();
        tick();
        check_eq("rstreq_no_spurious_wb", 32'(wb_regwrite), 32'd0);
        ex_regwrite = 1'b1; ex_regwraddr = 4'd9; ex_alu_out = 16'h0042;
        tick();
        set_nop();
        check_eq("rstreq_next_wb",   32'(wb_regwrite),  32'd1);
        check_eq("rstreq_next_addr", 32'(wb_regwraddr), 32'd9);
        check_eq("rstreq_next_data", 32'(wb_regwrdata), 32'h0042);
        tick();

`ifdef BUS_TIMEOUT_EN
        // no ack: aborts after 4 REQ cycles with all-ones data
        bus_op("tmo", 1'b0, 1'b0, 16'h8004, 16'h0000, 1'b1, 4'd2,
               0, 16'h0000, 10, 4, 5, 1, 16'hFFFF, 1);
`else
        // no ack: request stays pending, never errors, then reset clears it
        bus_op("noack", 1'b0, 1'b0, 16'h8004, 16'h0000, 1'b1, 4'd2,
               0, 16'h0000, 10, 9, 10, 0, 16'h0000, 0);
        rst_n = 1'b0;
        tick();
        check_eq("noack_req_after_rst", 32'(bus_if.req), 32'd0);
        rst_n = 1'b1;
        set_nop();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
